// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: shared types and sizing for the count_ctrl sequencer.
//   state_t  : sequencer FSM states (IDLE / RUN / DONE)
//   WIDTH_DEF: default count/limit width
//   WRAP_W   : width of the saturating periodic wrap counter
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned WRAP_W    = 8;

endpackage

// File: rtl/count_prescaler.sv
// count_prescaler: modulo-PRESC clock divider producing a step strobe.
//   clk     in  system clock, rising edge
//   rst_n   in  asynchronous active-low reset
//   i_clear in  force the phase counter back to 0 (wins over i_en)
//   i_en    in  advance the phase counter this cycle
//   o_step  out high in the cycle whose edge completes a PRESC-clock period
module count_prescaler #(
  parameter int unsigned PRESC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_en,
  output logic o_step
);

  // Keep at least one bit so PRESC=1 still yields a legal vector.
  localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;

  logic [PW-1:0] r_phase;
  logic          w_last;

  always_comb begin
    w_last = (r_phase == PW'(PRESC - 1));
    o_step = i_en && !i_clear && w_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase <= '0;
    end else if (i_clear) begin
      r_phase <= '0;
    end else if (i_en) begin
      if (w_last) begin
        r_phase <= '0;
      end else begin
        r_phase <= r_phase + PW'(1);
      end
    end
  end

endmodule

// File: rtl/count_ctrl.sv
// count_ctrl: command-driven sequencer for a WIDTH-bit up-counter.
//   clk          in  system clock, rising edge
//   rst_n        in  asynchronous active-low reset
//   cmd_valid    in  command offered
//   cmd_ready    out command can be accepted (IDLE and no abort)
//   cmd_limit    in  terminal count value
//   cmd_periodic in  1 = periodic, 0 = one-shot
//   abort        in  stop the current run
//   cnt          out current count value
//   busy         out high while not IDLE
//   done         out one-cycle pulse at terminal count
//   wrap_cnt     out saturating periodic wraps since last accepted command
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned PRESC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [WIDTH-1:0]  cmd_limit,
  input  logic              cmd_periodic,
  input  logic              abort,
  output logic [WIDTH-1:0]  cnt,
  output logic              busy,
  output logic              done,
  output logic [WRAP_W-1:0] wrap_cnt
);

  state_t             r_state;
  logic [WIDTH-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_limit;
  logic               r_periodic;
  logic               r_done;
  logic [WRAP_W-1:0]  r_wrap_cnt;

  logic               w_accept;
  logic               w_step;
  logic               w_presc_en;
  logic               w_presc_clr;
  logic [WIDTH-1:0]   w_cnt_inc;
  logic               w_terminal;

  always_comb begin
    cmd_ready   = (r_state == ST_IDLE) && !abort;
    w_accept    = cmd_valid && cmd_ready;
    // Prescaler only runs in RUN; any other state or an abort parks it at 0,
    // which also gives the zeroed phase required on every new command.
    w_presc_en  = (r_state == ST_RUN) && !abort;
    w_presc_clr = (r_state != ST_RUN) || abort;
    w_cnt_inc   = r_cnt + WIDTH'(1);
    w_terminal  = (w_cnt_inc == r_limit);
  end

  count_prescaler #(
    .PRESC (PRESC)
  ) u_presc (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (w_presc_clr),
    .i_en    (w_presc_en),
    .o_step  (w_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_limit    <= '0;
      r_periodic <= 1'b0;
      r_done     <= 1'b0;
      r_wrap_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_limit    <= cmd_limit;
            r_periodic <= cmd_periodic;
            r_cnt      <= '0;
            r_wrap_cnt <= '0;
            if (cmd_limit == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
          end else if (w_step) begin
            if (!w_terminal) begin
              r_cnt <= w_cnt_inc;
            end else if (r_periodic) begin
              r_cnt  <= '0;
              r_done <= 1'b1;
              if (r_wrap_cnt != '1) begin
                r_wrap_cnt <= r_wrap_cnt + WRAP_W'(1);
              end
            end else begin
              r_cnt   <= r_limit;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    cnt      = r_cnt;
    busy     = (r_state != ST_IDLE);
    done     = r_done;
    wrap_cnt = r_wrap_cnt;
  end

endmodule

// File: tb/tb_count_ctrl.sv
module tb_count_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       valid3 = 1'b0;
  logic [3:0] cmd_limit = '0;
  logic       cmd_periodic = 1'b0;
  logic       abort = 1'b0;

  logic       ready1, busy1, done1;
  logic [3:0] cnt1;
  logic [7:0] wrap1;
  logic       ready3, busy3, done3;
  logic [3:0] cnt3;
  logic [7:0] wrap3;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    string      tag;
    bit         d3;
    logic [3:0] cnt;
    logic       done;
    logic       busy;
    logic [7:0] wrap;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  count_ctrl #(.WIDTH(4), .PRESC(1)) u_dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (ready1),
    .cmd_limit    (cmd_limit),
    .cmd_periodic (cmd_periodic),
    .abort        (abort),
    .cnt          (cnt1),
    .busy         (busy1),
    .done         (done1),
    .wrap_cnt     (wrap1)
  );

  count_ctrl #(.WIDTH(4), .PRESC(3)) u_dut3 (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (valid3),
    .cmd_ready    (ready3),
    .cmd_limit    (cmd_limit),
    .cmd_periodic (cmd_periodic),
    .abort        (abort),
    .cnt          (cnt3),
    .busy         (busy3),
    .done         (done3),
    .wrap_cnt     (wrap3)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input bit d3, input int c, input bit dn,
                      input bit by, input int w);
    exp_t e;
    e.tag = tag; e.d3 = d3; e.cnt = 4'(c); e.done = dn; e.busy = by; e.wrap = 8'(w);
    sb.push_back(e);
  endtask

  // One clock: sample 1ns after the edge and compare against the oldest expectation.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL sb_underflow: observed empty expected entry");
    end else begin
      e = sb.pop_front();
      if (e.d3) begin
        chk({e.tag, ".cnt"},  8'(cnt3),  8'(e.cnt));
        chk({e.tag, ".done"}, 8'(done3), 8'(e.done));
        chk({e.tag, ".busy"}, 8'(busy3), 8'(e.busy));
        chk({e.tag, ".wrap"}, wrap3,     e.wrap);
      end else begin
        chk({e.tag, ".cnt"},  8'(cnt1),  8'(e.cnt));
        chk({e.tag, ".done"}, 8'(done1), 8'(e.done));
        chk({e.tag, ".busy"}, 8'(busy1), 8'(e.busy));
        chk({e.tag, ".wrap"}, wrap1,     e.wrap);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-shot limit=5 on the PRESC=1 instance, accept edge is the first tick.
  task automatic oneshot5(input string tag);
    cmd_limit = 4'd5; cmd_periodic = 1'b0; cmd_valid = 1'b1;
    push({tag, "_acc"}, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 5; k++) push($sformatf("%s_c%0d", tag, k), 0, k, (k == 5), 1, 0);
    push({tag, "_idle"}, 0, 5, 0, 0, 0);
    push({tag, "_hold"}, 0, 5, 0, 0, 0);
    run(1);
    cmd_valid = 1'b0;
    run(7);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_cnt1",   8'(cnt1),   8'd0);
    chk("rst_busy1",  8'(busy1),  8'd0);
    chk("rst_done1",  8'(done1),  8'd0);
    chk("rst_wrap1",  wrap1,      8'd0);
    chk("rst_ready1", 8'(ready1), 8'd1);
    chk("rst_ready3", 8'(ready3), 8'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // PRESC=1 one-shot limit=5
    oneshot5("os5");

    // PRESC=3 one-shot limit=2
    cmd_limit = 4'd2; cmd_periodic = 1'b0; valid3 = 1'b1;
    push("p3_acc", 1, 0, 0, 1, 0);
    push("p3_e1", 1, 0, 0, 1, 0);
    push("p3_e2", 1, 0, 0, 1, 0);
    push("p3_e3", 1, 1, 0, 1, 0);
    push("p3_e4", 1, 1, 0, 1, 0);
    push("p3_e5", 1, 1, 0, 1, 0);
    push("p3_e6", 1, 2, 1, 1, 0);
    push("p3_e7", 1, 2, 0, 0, 0);
    run(1);
    valid3 = 1'b0;
    run(7);

    // PRESC=1 periodic limit=3; valid held high and limit changed while running
    cmd_limit = 4'd3; cmd_periodic = 1'b1; cmd_valid = 1'b1;
    push("per_acc", 0, 0, 0, 1, 0);
    push("per_e1", 0, 1, 0, 1, 0);
    push("per_e2", 0, 2, 0, 1, 0);
    push("per_e3", 0, 0, 1, 1, 1);
    push("per_e4", 0, 1, 0, 1, 1);
    push("per_e5", 0, 2, 0, 1, 1);
    push("per_e6", 0, 0, 1, 1, 2);
    push("per_e7", 0, 1, 0, 1, 2);
    push("per_e8", 0, 2, 0, 1, 2);
    run(1);
    cmd_limit = 4'd7; cmd_periodic = 1'b0;
    chk("per_ready_run", 8'(ready1), 8'd0);
    run(8);

    // Abort on the terminal-step cycle
    abort = 1'b1;
    #1;
    chk("ab_ready_run", 8'(ready1), 8'd0);
    push("ab_e9", 0, 2, 0, 0, 2);
    push("ab_e10", 0, 2, 0, 0, 2);
    run(1);
    chk("ab_ready_idle", 8'(ready1), 8'd0);
    run(1);
    cmd_valid = 1'b0; abort = 1'b0;
    #1;
    chk("ab_ready_rel", 8'(ready1), 8'd1);

    // Zero limit command
    cmd_limit = 4'd0; cmd_periodic = 1'b0; cmd_valid = 1'b1;
    push("z_acc", 0, 0, 1, 1, 0);
    push("z_e1", 0, 0, 0, 0, 0);
    run(1);
    cmd_valid = 1'b0;
    run(1);
    abort = 1'b1; cmd_valid = 1'b1;
    #1;
    chk("z_ab_ready", 8'(ready1), 8'd0);
    push("z_ab_e", 0, 0, 0, 0, 0);
    push("z_ab_e2", 0, 0, 0, 0, 0);
    run(2);
    abort = 1'b0; cmd_valid = 1'b0;

    // Asynchronous reset mid-run (cnt=3)
    cmd_limit = 4'd5; cmd_periodic = 1'b1; cmd_valid = 1'b1;
    push("ar_acc", 0, 0, 0, 1, 0);
    push("ar_e1", 0, 1, 0, 1, 0);
    push("ar_e2", 0, 2, 0, 1, 0);
    push("ar_e3", 0, 3, 0, 1, 0);
    run(1);
    cmd_valid = 1'b0;
    run(3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_cnt",  8'(cnt1),   8'd0);
    chk("ar_busy", 8'(busy1),  8'd0);
    chk("ar_done", 8'(done1),  8'd0);
    chk("ar_wrap", wrap1,      8'd0);
    chk("ar_rdy",  8'(ready1), 8'd1);
    #1;
    rst_n = 1'b1;
    oneshot5("post");

    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_drain: observed %0d expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/count_ctrl.md
Name: count_ctrl

Overview:
Command-driven sequencer for a WIDTH-bit up-counter.
- Accepts a terminal value and a mode (one-shot or periodic) over a valid/ready handshake.
- Steps the count once every PRESC clocks and pulses done at terminal count.
- Sits between the software/sequencer command path and the counter datapath; busy and done feed the block-level status logic.

Parameters:
WIDTH, 4, width of count value and terminal limit
PRESC, 1, clocks per count step (legal range 1..256)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command can be accepted
cmd_limit  in  WIDTH  terminal count value
cmd_periodic  in  1  1 = periodic mode, 0 = one-shot mode
abort  in  1  stop the current run
cnt  out  WIDTH  current count value
busy  out  1  high while state != IDLE
done  out  1  one-cycle pulse at terminal count
wrap_cnt  out  8  periodic wraps since last accepted command (saturating)

Behaviour:
- Reset (asynchronous, immediate on rst_n low, including mid-run): state=IDLE, cnt=0, done=0, wrap_cnt=0, prescaler=0, latched limit/mode=0.
- Reset-state outputs: busy=0; cmd_ready=1 unless abort is high.
- States: IDLE, RUN, DONE. busy = (state != IDLE).
- cmd_ready = (state==IDLE) && !abort, decoded combinationally from state. Handshake = cmd_valid && cmd_ready at a rising edge.
- On handshake:
  - latch cmd_limit and cmd_periodic; later input changes have no effect until the next handshake;
  - cnt<=0, prescaler<=0, wrap_cnt<=0, state<=RUN.
- Handshake with cmd_limit==0, either mode: state<=DONE, done<=1 on the same edge, cnt stays 0.
- RUN, prescaler: counts 0..PRESC-1. A step occurs on the edge where prescaler==PRESC-1; that edge also returns prescaler to 0. With PRESC=1 every edge is a step.
- RUN, step where cnt+1 != limit: cnt<=cnt+1.
- RUN, step where cnt+1 == limit, one-shot: cnt<=limit, done<=1, state<=DONE.
- RUN, step where cnt+1 == limit, periodic: cnt<=0, done<=1, wrap_cnt<=wrap_cnt+1 saturating at 255, state stays RUN.
- DONE: lasts one cycle, then state<=IDLE. cnt holds until the next handshake.
- done is registered and high for exactly one cycle per terminal event.
- abort in RUN or DONE (highest priority): next edge state<=IDLE, cnt and wrap_cnt frozen, prescaler<=0, no done pulse even if that edge was a terminal step. abort in IDLE: no effect other than blocking cmd_ready.
- Arithmetic: cnt never exceeds limit, so cnt+1 never overflows WIDTH bits. wrap_cnt never wraps.
- Latency: one-shot, command accept to done = limit*PRESC clocks.

Decomposition:
- Package count_ctrl_pkg: state enum (IDLE/RUN/DONE), default WIDTH, WRAP_W=8.
- Sub-module count_prescaler: PRESC-modulo counter with a clear input and a one-cycle step strobe output.
- The FSM and count register live in count_ctrl.

Test Plan:
- PRESC=1, one-shot, limit=5, accept at edge N -> cnt=1..5 after edges N+1..N+5; done=1 only after N+5; busy=0 after N+6; cnt holds 5.
- PRESC=3, one-shot, limit=2, accept at N -> cnt=1 after N+3; cnt=2 and done=1 after N+6; no other done.
- PRESC=1, periodic, limit=3 -> cnt sequence 1,2,0,1,2,0; done after N+3 and N+6; wrap_cnt=2 after N+6; busy stays 1; cmd_valid during RUN is not accepted.
- Periodic run, abort asserted in the cycle of a terminal step (cnt=2, limit=3) -> no done; state IDLE next edge; cnt=2 held; wrap_cnt unchanged; cmd_ready=1 once abort drops.
- cmd_limit=0 with cmd_valid=1 in IDLE -> done=1 after the accept edge; cnt=0; busy=1 for one cycle then 0. Same command with abort=1 -> cmd_ready=0, not accepted.
- rst_n low mid-run (cnt=3, PRESC=1) -> cnt=0, busy=0, wrap_cnt=0 immediately, without waiting for a clock edge. After release, a new command behaves as in the first scenario.
